fetch_unit: RTL

- Instruction-fetch stage of the MIPS32 SOC CPU.
- Holds the program counter and issues word fetches over a req/ready handshake to instruction memory.
- Presents fetched instructions to decode through a valid/stall interface with a one-entry skid buffer.
- Consumes the BranchResolver's branchTaken (plus jump redirects) to redirect the PC, flush fetched-but-unconsumed instructions and discard in-flight responses.

---
 rtl/fetch_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
//   Holds the PC, issues word fetches to instruction memory over a req/ready
//   handshake, and presents fetched words to decode through a valid/stall
//   interface backed by a one-entry skid buffer. Branch/jump redirects reload
//   the PC, flush buffered instructions and kill any in-flight response.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   branchTaken, branchTarget   taken-branch redirect (wins over jump)
//   jump, jumpTarget            jump redirect
//   stall                       decode cannot accept this cycle
//   imemReq, imemAddr           fetch request / word address
//   imemReady, imemData         transaction complete / fetched word
//   instr, instrPc, instrValid  instruction presented to decode
//   alignErr                    one-cycle pulse on a misaligned redirect target
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  input  logic        stall,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  output logic        instrValid,
  output logic        alignErr
);

  typedef enum logic [1:0] {StIdle, StBusy, StDrain} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_req_addr;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_valid;
  logic [31:0] r_skid_instr;
  logic [31:0] r_skid_pc;
  logic        r_skid_valid;
  logic        r_align_err;

  logic        w_redirect;
  logic [31:0] w_target_raw;
  logic [31:0] w_target;
  logic        w_accept;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_complete;
  logic        w_issue;
  logic        w_deliver;

  assign w_redirect   = branchTaken | jump;
  // Branch is the older instruction, so it takes priority over a jump.
  assign w_target_raw = branchTaken ? branchTarget : jumpTarget;
  assign w_target     = {w_target_raw[31:2], 2'b00};
  assign w_accept     = r_valid & ~stall;

  always_comb begin
    w_req  = 1'b0;
    w_addr = r_pc;
    unique case (r_state)
      StIdle: begin
        // A full skid means both entries are occupied: hold off new fetches.
        w_req  = ~w_redirect & ~r_skid_valid;
        w_addr = r_pc;
      end
      StBusy, StDrain: begin
        w_req  = 1'b1;
        w_addr = r_req_addr;
      end
      default: begin
        w_req  = 1'b0;
        w_addr = r_pc;
      end
    endcase
    if (!rst) w_req = 1'b0;
  end

  assign w_complete = w_req & imemReady;
  assign w_issue    = (r_state == StIdle) & w_req;
  // Responses in DRAIN or during a redirect belong to a flushed path.
  assign w_deliver  = w_complete & ~w_redirect & (r_state != StDrain);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StIdle;
      r_pc         <= RESET_PC;
      r_req_addr   <= 32'h0;
      r_instr      <= 32'h0;
      r_instr_pc   <= 32'h0;
      r_valid      <= 1'b0;
      r_skid_instr <= 32'h0;
      r_skid_pc    <= 32'h0;
      r_skid_valid <= 1'b0;
      r_align_err  <= 1'b0;
    end else begin
      r_align_err <= w_redirect & (|w_target_raw[1:0]);

      if (w_issue) r_req_addr <= r_pc;

      if (w_redirect) begin
        r_pc <= w_target;
      end else if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end

      if (w_redirect) begin
        r_valid      <= 1'b0;
        r_skid_valid <= 1'b0;
      end else if (w_deliver) begin
        // Skid is always empty here: a request is only issued with skid empty.
        if (!r_valid || w_accept) begin
          r_instr    <= imemData;
          r_instr_pc <= w_addr;
          r_valid    <= 1'b1;
        end else begin
          r_skid_instr <= imemData;
          r_skid_pc    <= w_addr;
          r_skid_valid <= 1'b1;
        end
      end else if (w_accept) begin
        if (r_skid_valid) begin
          r_instr      <= r_skid_instr;
          r_instr_pc   <= r_skid_pc;
          r_skid_valid <= 1'b0;
        end else begin
          r_valid <= 1'b0;
        end
      end

      unique case (r_state)
        StIdle: begin
          if (w_issue && !imemReady) r_state <= StBusy;
        end
        StBusy: begin
          if (w_complete) begin
            r_state <= StIdle;
          end else if (w_redirect) begin
            r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_complete) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign imemReq    = w_req;
  assign imemAddr   = w_addr;
  assign instr      = r_instr;
  assign instrPc    = r_instr_pc;
  assign instrValid = r_valid;
  assign alignErr   = r_align_err;

endmodule
